// File: rtl/color_match_judge.sv
// Round referee: accepts a platform/ball color set over ready/valid, waits for a
// landing or timeout, judges it and keeps score, lives and game-over state.
module color_match_judge #(
    parameter int NUM_LIVES      = 3,
    parameter int SCORE_WIDTH    = 8,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [11:0]            plats_color,
    input  logic [2:0]             ball_color,
    input  logic                   colors_valid,
    output logic                   colors_ready,
    input  logic                   land,
    input  logic [1:0]             land_plat,
    input  logic                   start,
    output logic                   match,
    output logic                   miss,
    output logic                   void_round,
    output logic [SCORE_WIDTH-1:0] score,
    output logic [3:0]             lives,
    output logic                   game_over
);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_ARMED = 2'd1,
        ST_OVER  = 2'd2
    } state_t;

    localparam logic [3:0]             LIVES_INIT = 4'(NUM_LIVES);
    localparam logic                   TO_EN      = (TIMEOUT_CYCLES != 0);
    localparam logic [19:0]            TO_LAST    = 20'(TIMEOUT_CYCLES - 1);
    localparam logic [SCORE_WIDTH-1:0] SCORE_MAX  = {SCORE_WIDTH{1'b1}};

    // True when no platform in the set carries the ball color.
    function automatic logic is_unwinnable(input logic [11:0] plats, input logic [2:0] ball);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (plats[3*i +: 3] == ball) begin
                hit = 1'b1;
            end
        end
        return !hit;
    endfunction

    state_t                   state_r;
    logic [11:0]              plats_r;
    logic [2:0]               ball_r;
    logic                     unwin_r;
    logic [19:0]              cnt_r;
    logic                     ready_r;
    logic                     over_r;
    logic                     match_r;
    logic                     miss_r;
    logic                     void_r;
    logic [SCORE_WIDTH-1:0]   score_r;
    logic [3:0]               lives_r;

    logic [2:0]               land_color_s;
    logic                     timeout_s;
    logic                     judge_s;
    logic                     win_s;

    // Color of the touched platform, taken from the latched set.
    always_comb begin
        land_color_s = 3'd0;
        case (land_plat)
            2'd0:    land_color_s = plats_r[2:0];
            2'd1:    land_color_s = plats_r[5:3];
            2'd2:    land_color_s = plats_r[8:6];
            2'd3:    land_color_s = plats_r[11:9];
            default: land_color_s = 3'd0;
        endcase
    end

    // A timeout without a landing counts as a wrong landing; a real landing wins the tie.
    always_comb begin
        timeout_s = 1'b0;
        if (TO_EN && (cnt_r == TO_LAST)) begin
            timeout_s = 1'b1;
        end else begin
            timeout_s = 1'b0;
        end
        judge_s = land || timeout_s;
        win_s   = land && (land_color_s == ball_r);
    end

    // Round FSM with registered handshake, status and result pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_LOAD;
            plats_r <= 12'd0;
            ball_r  <= 3'd0;
            unwin_r <= 1'b0;
            cnt_r   <= 20'd0;
            ready_r <= 1'b1;
            over_r  <= 1'b0;
            match_r <= 1'b0;
            miss_r  <= 1'b0;
            void_r  <= 1'b0;
            score_r <= '0;
            lives_r <= LIVES_INIT;
        end else begin
            match_r <= 1'b0;
            miss_r  <= 1'b0;
            void_r  <= 1'b0;
            case (state_r)
                ST_LOAD: begin
                    if (colors_valid) begin
                        plats_r <= plats_color;
                        ball_r  <= ball_color;
                        unwin_r <= is_unwinnable(plats_color, ball_color);
                        cnt_r   <= 20'd0;
                        ready_r <= 1'b0;
                        state_r <= ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (judge_s) begin
                        if (unwin_r) begin
                            void_r  <= 1'b1;
                            ready_r <= 1'b1;
                            state_r <= ST_LOAD;
                        end else if (win_s) begin
                            match_r <= 1'b1;
                            if (score_r != SCORE_MAX) begin
                                score_r <= score_r + {{(SCORE_WIDTH-1){1'b0}}, 1'b1};
                            end
                            ready_r <= 1'b1;
                            state_r <= ST_LOAD;
                        end else begin
                            miss_r <= 1'b1;
                            if (lives_r != 4'd0) begin
                                lives_r <= lives_r - 4'd1;
                            end
                            if (lives_r <= 4'd1) begin
                                over_r  <= 1'b1;
                                state_r <= ST_OVER;
                            end else begin
                                ready_r <= 1'b1;
                                state_r <= ST_LOAD;
                            end
                        end
                    end else if (TO_EN) begin
                        cnt_r <= cnt_r + 20'd1;
                    end
                end
                ST_OVER: begin
                    if (start) begin
                        score_r <= '0;
                        lives_r <= LIVES_INIT;
                        over_r  <= 1'b0;
                        ready_r <= 1'b1;
                        state_r <= ST_LOAD;
                    end
                end
                default: begin
                    over_r  <= 1'b0;
                    ready_r <= 1'b1;
                    state_r <= ST_LOAD;
                end
            endcase
        end
    end

    assign colors_ready = ready_r;
    assign game_over    = over_r;
    assign match        = match_r;
    assign miss         = miss_r;
    assign void_round   = void_r;
    assign score        = score_r;
    assign lives        = lives_r;

endmodule

// File: tb/tb_color_match_judge.sv
// Bench for color_match_judge: directed vector table, then random rounds
// checked against a round-level game model.
module tb_color_match_judge;

    localparam int NL = 3;
    localparam int SW = 2;
    localparam int TO = 10;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [11:0]   plats_color = 12'd0;
    logic [2:0]    ball_color = 3'd0;
    logic          colors_valid = 1'b0;
    logic          colors_ready;
    logic          land = 1'b0;
    logic [1:0]    land_plat = 2'd0;
    logic          start = 1'b0;
    logic          match, miss, void_round;
    logic [SW-1:0] score;
    logic [3:0]    lives;
    logic          game_over;

    int tests = 0;
    int fails = 0;

    color_match_judge #(.NUM_LIVES(NL), .SCORE_WIDTH(SW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .plats_color(plats_color), .ball_color(ball_color),
        .colors_valid(colors_valid), .colors_ready(colors_ready), .land(land),
        .land_plat(land_plat), .start(start), .match(match), .miss(miss),
        .void_round(void_round), .score(score), .lives(lives), .game_over(game_over)
    );

    always #5 clk = ~clk;

    // Game model: a round is "open" after a set is taken; its age counts edges since then.
    bit in_round = 1'b0;
    bit ended    = 1'b0;
    int age      = 0;
    int cols[4]  = '{0, 0, 0, 0};
    int ball_m   = 0;
    int sc_m     = 0;
    int li_m     = NL;
    bit em_m = 1'b0, emi_m = 1'b0, ev_m = 1'b0;

    task automatic model_step();
        bit winnable;
        em_m = 1'b0; emi_m = 1'b0; ev_m = 1'b0;
        if (reset) begin
            in_round = 1'b0; ended = 1'b0; sc_m = 0; li_m = NL; age = 0;
        end else if (ended) begin
            if (start) begin
                ended = 1'b0; sc_m = 0; li_m = NL;
            end
        end else if (!in_round) begin
            if (colors_valid) begin
                for (int i = 0; i < 4; i++) cols[i] = int'(plats_color[3*i +: 3]);
                ball_m = int'(ball_color);
                in_round = 1'b1;
                age = 0;
            end
        end else begin
            age++;
            if (land || (TO > 0 && age == TO)) begin
                winnable = 1'b0;
                for (int i = 0; i < 4; i++) if (cols[i] == ball_m) winnable = 1'b1;
                if (!winnable) begin
                    ev_m = 1'b1;
                end else if (land && cols[land_plat] == ball_m) begin
                    em_m = 1'b1;
                    if (sc_m < (1 << SW) - 1) sc_m++;
                end else begin
                    emi_m = 1'b1;
                    if (li_m > 0) li_m--;
                    if (li_m == 0) ended = 1'b1;
                end
                in_round = 1'b0;
            end
        end
    endtask

    task automatic drive(input logic r, input logic cv, input logic [11:0] p, input logic [2:0] b,
                         input logic ld, input logic [1:0] lp, input logic st);
        @(negedge clk);
        reset = r; colors_valid = cv; plats_color = p; ball_color = b;
        land = ld; land_plat = lp; start = st;
        @(posedge clk);
        model_step();
        #1;
    endtask

    typedef struct {
        string       name;
        logic        r, cv;
        logic [11:0] p;
        logic [2:0]  b;
        logic        ld;
        logic [1:0]  lp;
        logic        st;
        int          idle;
        logic [6:0]  exp;   // {match, miss, void_round, ready, game_over} ++ packed below
        logic [1:0]  esc;
        logic [3:0]  eli;
    } row_t;

    row_t rows[$];

    function automatic row_t mk(string n, logic r, logic cv, logic [11:0] p, logic [2:0] b,
                                logic ld, logic [1:0] lp, logic st, int idle,
                                logic em, logic emi, logic ev, logic [1:0] sc, logic [3:0] li,
                                logic rdy, logic ov);
        row_t x;
        x.name = n; x.r = r; x.cv = cv; x.p = p; x.b = b; x.ld = ld; x.lp = lp; x.st = st;
        x.idle = idle; x.exp = {2'b00, em, emi, ev, rdy, ov}; x.esc = sc; x.eli = li;
        return x;
    endfunction

    initial begin
        logic [11:0] rp;
        logic [2:0]  rb;
        logic [6:0]  got;
        int          lprob;

        //                  name           r    cv   plats     ball  ld   lp    st  idle em   emi  ev   sc    li    rdy  ov
        rows.push_back(mk("reset",        1'b1,1'b0,12'o0000,3'd0,1'b0,2'd0,1'b0,0,1'b0,1'b0,1'b0,2'd0,4'd3,1'b1,1'b0));
        rows.push_back(mk("accept1",      1'b0,1'b1,12'o1234,3'd3,1'b0,2'd0,1'b0,0,1'b0,1'b0,1'b0,2'd0,4'd3,1'b0,1'b0));
        rows.push_back(mk("match1",       1'b0,1'b0,12'o0000,3'd0,1'b1,2'd1,1'b0,0,1'b1,1'b0,1'b0,2'd1,4'd3,1'b1,1'b0));
        rows.push_back(mk("accept2",      1'b0,1'b1,12'o1234,3'd3,1'b0,2'd0,1'b0,0,1'b0,1'b0,1'b0,2'd1,4'd3,1'b0,1'b0));
        rows.push_back(mk("miss1",        1'b0,1'b0,12'o0000,3'd0,1'b1,2'd0,1'b0,0,1'b0,1'b1,1'b0,2'd1,4'd2,1'b1,1'b0));
        rows.push_back(mk("accept3",      1'b0,1'b1,12'o1234,3'd3,1'b0,2'd0,1'b0,0,1'b0,1'b0,1'b0,2'd1,4'd2,1'b0,1'b0));
        rows.push_back(mk("miss2",        1'b0,1'b0,12'o0000,3'd0,1'b1,2'd2,1'b0,0,1'b0,1'b1,1'b0,2'd1,4'd1,1'b1,1'b0));
        rows.push_back(mk("accept4",      1'b0,1'b1,12'o1234,3'd3,1'b0,2'd0,1'b0,0,1'b0,1'b0,1'b0,2'd1,4'd1,1'b0,1'b0));
        rows.push_back(mk("miss3_over",   1'b0,1'b0,12'o0000,3'd0,1'b1,2'd3,1'b0,0,1'b0,1'b1,1'b0,2'd1,4'd0,1'b0,1'b1));
        rows.push_back(mk("over_ignore",  1'b0,1'b1,12'o1234,3'd3,1'b1,2'd1,1'b0,0,1'b0,1'b0,1'b0,2'd1,4'd0,1'b0,1'b1));
        rows.push_back(mk("restart",      1'b0,1'b1,12'o1234,3'd3,1'b0,2'd0,1'b1,0,1'b0,1'b0,1'b0,2'd0,4'd3,1'b1,1'b0));
        rows.push_back(mk("accept_to",    1'b0,1'b1,12'o1234,3'd3,1'b0,2'd0,1'b0,0,1'b0,1'b0,1'b0,2'd0,4'd3,1'b0,1'b0));
        rows.push_back(mk("pre_timeout",  1'b0,1'b0,12'o0000,3'd0,1'b0,2'd0,1'b0,8,1'b0,1'b0,1'b0,2'd0,4'd3,1'b0,1'b0));
        rows.push_back(mk("timeout_miss", 1'b0,1'b0,12'o0000,3'd0,1'b0,2'd0,1'b0,0,1'b0,1'b1,1'b0,2'd0,4'd2,1'b1,1'b0));
        rows.push_back(mk("accept_to2",   1'b0,1'b1,12'o1234,3'd3,1'b0,2'd0,1'b0,0,1'b0,1'b0,1'b0,2'd0,4'd2,1'b0,1'b0));
        rows.push_back(mk("land_at_to",   1'b0,1'b0,12'o0000,3'd0,1'b1,2'd1,1'b0,9,1'b1,1'b0,1'b0,2'd1,4'd2,1'b1,1'b0));
        rows.push_back(mk("accept_unw",   1'b0,1'b1,12'o1111,3'd5,1'b0,2'd0,1'b0,0,1'b0,1'b0,1'b0,2'd1,4'd2,1'b0,1'b0));
        rows.push_back(mk("void_land",    1'b0,1'b0,12'o0000,3'd0,1'b1,2'd2,1'b0,0,1'b0,1'b0,1'b1,2'd1,4'd2,1'b1,1'b0));
        rows.push_back(mk("accept_unw2",  1'b0,1'b1,12'o1111,3'd5,1'b0,2'd0,1'b0,0,1'b0,1'b0,1'b0,2'd1,4'd2,1'b0,1'b0));
        rows.push_back(mk("void_timeout", 1'b0,1'b0,12'o0000,3'd0,1'b0,2'd0,1'b0,9,1'b0,1'b0,1'b1,2'd1,4'd2,1'b1,1'b0));
        rows.push_back(mk("hold_acc1",    1'b0,1'b1,12'o1234,3'd3,1'b0,2'd0,1'b0,0,1'b0,1'b0,1'b0,2'd1,4'd2,1'b0,1'b0));
        rows.push_back(mk("hold_match1",  1'b0,1'b1,12'o7777,3'd7,1'b1,2'd1,1'b0,0,1'b1,1'b0,1'b0,2'd2,4'd2,1'b1,1'b0));
        rows.push_back(mk("hold_acc2",    1'b0,1'b1,12'o1234,3'd3,1'b0,2'd0,1'b0,0,1'b0,1'b0,1'b0,2'd2,4'd2,1'b0,1'b0));
        rows.push_back(mk("hold_match2",  1'b0,1'b1,12'o0000,3'd0,1'b1,2'd1,1'b0,0,1'b1,1'b0,1'b0,2'd3,4'd2,1'b1,1'b0));
        rows.push_back(mk("hold_acc3",    1'b0,1'b1,12'o1234,3'd3,1'b0,2'd0,1'b0,0,1'b0,1'b0,1'b0,2'd3,4'd2,1'b0,1'b0));
        rows.push_back(mk("saturate",     1'b0,1'b0,12'o0000,3'd0,1'b1,2'd1,1'b0,0,1'b1,1'b0,1'b0,2'd3,4'd2,1'b1,1'b0));
        rows.push_back(mk("accept_b2b",   1'b0,1'b1,12'o1234,3'd3,1'b0,2'd0,1'b0,0,1'b0,1'b0,1'b0,2'd3,4'd2,1'b0,1'b0));
        rows.push_back(mk("match_b2b",    1'b0,1'b0,12'o0000,3'd0,1'b1,2'd1,1'b0,0,1'b1,1'b0,1'b0,2'd3,4'd2,1'b1,1'b0));
        rows.push_back(mk("land_in_load", 1'b0,1'b0,12'o0000,3'd0,1'b1,2'd1,1'b0,0,1'b0,1'b0,1'b0,2'd3,4'd2,1'b1,1'b0));
        rows.push_back(mk("accept_rst",   1'b0,1'b1,12'o1234,3'd3,1'b0,2'd0,1'b0,0,1'b0,1'b0,1'b0,2'd3,4'd2,1'b0,1'b0));
        rows.push_back(mk("reset_armed",  1'b1,1'b0,12'o0000,3'd0,1'b0,2'd0,1'b0,0,1'b0,1'b0,1'b0,2'd0,4'd3,1'b1,1'b0));
        rows.push_back(mk("land_after_rst",1'b0,1'b0,12'o0000,3'd0,1'b1,2'd1,1'b0,0,1'b0,1'b0,1'b0,2'd0,4'd3,1'b1,1'b0));

        foreach (rows[k]) begin
            for (int j = 0; j < rows[k].idle; j++) drive(1'b0, 1'b0, 12'd0, 3'd0, 1'b0, 2'd0, 1'b0);
            drive(rows[k].r, rows[k].cv, rows[k].p, rows[k].b, rows[k].ld, rows[k].lp, rows[k].st);
            got = {2'b00, match, miss, void_round, colors_ready, game_over};
            tests++;
            if (got !== rows[k].exp || score !== rows[k].esc || lives !== rows[k].eli) begin
                fails++;
                $display("FAIL %s: got m/mi/v/rdy/ov=%b score=%0d lives=%0d, want %b score=%0d lives=%0d",
                         rows[k].name, got[4:0], score, lives, rows[k].exp[4:0], rows[k].esc, rows[k].eli);
            end
        end

        for (int i = 0; i < 4000; i++) begin
            lprob = ((i / 400) % 2 == 0) ? 3 : 25;
            rp = 12'($urandom);
            if ($urandom_range(0, 1) == 1) rb = rp[3*$urandom_range(0, 3) +: 3];
            else rb = 3'($urandom);
            drive(($urandom_range(0, 299) == 0), ($urandom_range(0, 1) == 1), rp, rb,
                  ($urandom_range(0, lprob - 1) == 0), 2'($urandom), ($urandom_range(0, 7) == 0));
            tests++;
            if (match !== em_m || miss !== emi_m || void_round !== ev_m ||
                colors_ready !== (!ended && !in_round) || game_over !== ended ||
                score !== SW'(sc_m) || lives !== 4'(li_m)) begin
                fails++;
                $display("FAIL rand%0d: got m=%b mi=%b v=%b rdy=%b ov=%b sc=%0d li=%0d, want m=%b mi=%b v=%b rdy=%b ov=%b sc=%0d li=%0d",
                         i, match, miss, void_round, colors_ready, game_over, score, lives,
                         em_m, emi_m, ev_m, !ended && !in_round, ended, sc_m, li_m);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/color_match_judge.md
# color_match_judge

Round referee that consumes the platform/ball color sets produced by the color randomizer. It accepts a four-platform color set plus a ball color through a ready/valid handshake, then waits for the ball to land or for a timeout. It judges the landing against the latched colors and maintains score, lives and game-over state. It sits between the color generator and the display/score logic.

## Interface
- `NUM_LIVES`, default 3: lives at reset and restart; range 1–15.
- `SCORE_WIDTH`, default 8: width of the score counter.
- `TIMEOUT_CYCLES`, default 1000: cycles allowed in ARMED before a forced miss; 0 disables the timeout; range up to 2^20-1.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  reset, synchronous, active-high.
- `plats_color`  in  12  four 3-bit platform colors; platform i at [3i+2:3i].
- `ball_color`  in  3  ball color for the offered round.
- `colors_valid`  in  1  generator presents a round's color set.
- `colors_ready`  out  1  judge can accept a color set; high only in LOAD.
- `land`  in  1  single-cycle pulse: the ball touched a platform.
- `land_plat`  in  2  index of the touched platform; sampled with `land`.
- `start`  in  1  restart request; honoured only in OVER.
- `match`  out  1  one-cycle pulse: correct landing.
- `miss`  out  1  one-cycle pulse: wrong platform or timeout.
- `void_round`  out  1  one-cycle pulse: the round was unwinnable (no platform has the ball color).
- `score`  out  SCORE_WIDTH  count of matches.
- `lives`  out  4  remaining lives.
- `game_over`  out  1  high while in OVER.

## Operation
- The FSM has three states:
  - **LOAD**: `colors_ready`=1. On `colors_valid`, latch `plats_color` and `ball_color`, clear the timeout counter, and go to ARMED.
  - **ARMED**: `colors_ready`=0. Wait for `land` or timeout.
  - **OVER**: `game_over`=1. On `start`: score←0, lives←NUM_LIVES, go to LOAD.
- Unwinnable flag: computed at latch time and registered. It is set when the latched ball color equals none of the four latched platform colors.
- Judging happens in ARMED when `land` is sampled:
  - **Unwinnable round**: `void_round` pulse; score and lives unchanged; go to LOAD.
  - **Platform color == ball color**: `match` pulse; score+1, saturating at 2^SCORE_WIDTH-1; go to LOAD.
  - **Otherwise**: `miss` pulse; lives-1; go to OVER if lives becomes 0, else LOAD.
- Timeout:
  - The counter increments each ARMED cycle.
  - When it reaches TIMEOUT_CYCLES-1 without `land`, the round is judged as a wrong landing.
  - An unwinnable round that times out yields `void_round`, not `miss`.
- Inputs in the wrong state are ignored, with no side effects:
  - `land` outside ARMED.
  - `colors_valid` outside LOAD.
  - `start` outside OVER.
- Lives never decrement below 0. Score never wraps.
- Exactly one of `match` / `miss` / `void_round` fires per judged round.

## Timing
- Reset values:
  - state LOAD, so `colors_ready`=1.
  - `match`=`miss`=`void_round`=0.
  - score=0, lives=NUM_LIVES, `game_over`=0.
  - latched colors 0, timeout counter 0.
- Handshake:
  - Transfer happens at the edge where `colors_valid` && `colors_ready`.
  - `colors_ready` drops in the next cycle.
  - The generator may change its outputs freely after the transfer edge.
- Judge latency: 1 cycle. For `land` sampled at edge T:
  - The result pulse is high for the cycle after T.
  - `score`/`lives` update at edge T.
  - The state is LOAD/OVER after T, so `colors_ready` or `game_over` is high in that same cycle.
- Back-to-back rounds:
  - A new set can be accepted at edge T+1, so minimum round length is 2 cycles.
  - `land` at T+1 is ignored because the state is LOAD.
- Timeout:
  - Set accepted at edge A → forced judgment at edge A+TIMEOUT_CYCLES.
  - The result pulse follows one cycle later.
- Simultaneous events:
  - `land` on the timeout edge: the landing is judged and the timeout is discarded.
  - `start` together with `colors_valid` in OVER: only `start` acts.
- Reset mid-round, asserted in any state, overrides everything. No result pulse is produced for the aborted round.

## Test plan
- **Match and miss rounds.** Reset. Then:
  - Offer plats=12'o1234 (p0=4, p1=3, p2=2, p3=1) with ball=3, land_plat=1 → `match` pulse 1 cycle after `land`; score=1; lives=3; `colors_ready` high that cycle.
  - Next round, same colors, land_plat=0 → `miss`; lives=2; score=1.
- **Game over and restart.** With NUM_LIVES=3, three wrong landings → third `miss` coincides with `game_over`=1 and lives=0; `colors_ready`=0. `land`/`colors_valid` in OVER → no change. `start` → score=0, lives=3, `colors_ready`=1 next cycle.
- **Timeout.** With TIMEOUT_CYCLES=10, accept a set at edge A with no `land` → `miss` high in the cycle after edge A+10; lives-1. Repeat with `land` (correct platform) on edge A+10 → `match` only.
- **Unwinnable round.** plats=12'o1111, ball=5: `land` on any platform → `void_round` pulse, score/lives unchanged. Same set with a timeout → `void_round`.
- **Saturation and handshake.** With SCORE_WIDTH=2, four matches → score stays 3. `colors_valid` held high continuously: one set accepted per round. Color inputs changing during ARMED do not affect judgment.
- **Reset mid-round.** Assert `reset` in ARMED one cycle before `land` → no pulse; score=0, lives=NUM_LIVES, `colors_ready`=1 after reset.
